// File: rtl/mem_xfer_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_xfer_sequencer_if
//
// Bundles the control handshake and both memory buses of the copy sequencer.
//
// Signals:
//   start     controller -> sequencer  one-cycle request to begin a transfer
//   src_base  controller -> sequencer  first memory A address
//   dst_base  controller -> sequencer  first memory B address
//   length    controller -> sequencer  number of words to copy
//   hold      controller -> sequencer  suspends issue of new reads
//   rdataA    memory A   -> sequencer  read data, RD_LAT cycles after reA
//   reA       sequencer  -> memory A   read enable
//   addrA     sequencer  -> memory A   read address
//   WEB       sequencer  -> memory B   write enable
//   addrB     sequencer  -> memory B   write address
//   wdataB    sequencer  -> memory B   write data
//   busy      sequencer  -> controller transfer in progress
//   done      sequencer  -> controller one-cycle completion pulse
//
// Modports:
//   slave   the sequencer itself
//   master  the system controller together with memories A and B
// ---------------------------------------------------------------------------
interface mem_xfer_sequencer_if #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int LEN_W = 5
);

  logic             start;
  logic [AW-1:0]    src_base;
  logic [AW-1:0]    dst_base;
  logic [LEN_W-1:0] length;
  logic             hold;
  logic [DW-1:0]    rdataA;

  logic             reA;
  logic [AW-1:0]    addrA;
  logic             WEB;
  logic [AW-1:0]    addrB;
  logic [DW-1:0]    wdataB;
  logic             busy;
  logic             done;

  modport slave (
    input  start, src_base, dst_base, length, hold, rdataA,
    output reA, addrA, WEB, addrB, wdataB, busy, done
  );

  modport master (
    output start, src_base, dst_base, length, hold, rdataA,
    input  reA, addrA, WEB, addrB, wdataB, busy, done
  );

endinterface

// File: rtl/mem_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// mem_xfer_sequencer
//
// Copies a block of words from memory A to memory B. A start pulse latches
// the source base, destination base and length; the sequencer then issues
// consecutive reads to A, follows A's fixed read latency with a valid
// pipeline, and writes each returned word to consecutive addresses of B.
// Progress is reported to the controller through busy and a done pulse.
//
// Parameters:
//   AW      address width of memories A and B
//   DW      data word width
//   LEN_W   width of the length field and of the read/write counters
//   RD_LAT  memory A read latency in cycles (1..4)
//
// Ports:
//   clock   system clock, everything on the rising edge
//   Reset   synchronous, active-high reset
//   bus     slave side of mem_xfer_sequencer_if (handshake + memory buses)
//
// Every output is a flop. The combinational block therefore computes the
// values the outputs take in the cycle that follows the next clock edge,
// using the inputs sampled at that edge. A read issued in cycle t has its
// data sampled at the edge closing cycle t+RD_LAT and is written to B in
// cycle t+RD_LAT+1.
// ---------------------------------------------------------------------------
module mem_xfer_sequencer #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int LEN_W  = 5,
  parameter int RD_LAT = 1
) (
  input  logic                 clock,
  input  logic                 Reset,
  mem_xfer_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;

  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [RD_LAT-1:0] vld_q, vld_d;

  logic             re_a_q, re_a_d;
  logic [AW-1:0]    addr_a_q, addr_a_d;
  logic             we_b_q, we_b_d;
  logic [AW-1:0]    addr_b_q, addr_b_d;
  logic [DW-1:0]    wdata_b_q, wdata_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Values used by the read-issue step. In IDLE they come straight from the
  // start request so the first read goes out in the very first ISSUE cycle;
  // afterwards they come from the latched transfer descriptor.
  logic             issue_en;
  logic [AW-1:0]    eff_src;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] eff_rd_cnt;

  // Base plus word index, wrapping modulo 2^AW. The size cast either
  // truncates or zero-extends the index to the address width.
  function automatic logic [AW-1:0] offset_addr(input logic [AW-1:0]    base,
                                                input logic [LEN_W-1:0] idx);
    return base + AW'(idx);
  endfunction

  // Valid pipeline: bit i is high in cycle t+1+i when a read was issued in
  // cycle t. The top bit therefore marks the cycle in which that read's data
  // is sampled from memory A.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = re_a_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Next-state and registered-output logic. Read issue and write retirement
  // are independent: writes are driven only by the valid pipeline, so they
  // keep flowing while hold suspends reads and during DRAIN.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    re_a_d     = 1'b0;
    addr_a_d   = addr_a_q;
    we_b_d     = 1'b0;
    addr_b_d   = addr_b_q;
    wdata_b_d  = wdata_b_q;
    done_d     = 1'b0;
    issue_en   = 1'b0;
    eff_src    = src_q;
    eff_len    = len_q;
    eff_rd_cnt = rd_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ISSUE;
            src_d      = bus.src_base;
            dst_d      = bus.dst_base;
            len_d      = bus.length;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            issue_en   = 1'b1;
            eff_src    = bus.src_base;
            eff_len    = bus.length;
            eff_rd_cnt = '0;
          end
        end
      end
      ISSUE: begin
        issue_en = 1'b1;
      end
      DRAIN: begin
        if (wr_cnt_q == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Issue one read per non-held ISSUE cycle; the read carrying index
    // len-1 is the last one, after which only the writes remain.
    if (issue_en && !bus.hold) begin
      re_a_d   = 1'b1;
      addr_a_d = offset_addr(eff_src, eff_rd_cnt);
      rd_cnt_d = eff_rd_cnt + LEN_W'(1);
      if (eff_rd_cnt == eff_len - LEN_W'(1)) begin
        state_d = DRAIN;
      end
    end

    // Retire the oldest outstanding read as a write to memory B. Reads and
    // writes pair up in order, so the write index is simply wr_cnt.
    if (vld_q[RD_LAT-1]) begin
      we_b_d    = 1'b1;
      addr_b_d  = offset_addr(dst_q, wr_cnt_q);
      wdata_b_d = bus.rdataA;
      wr_cnt_d  = wr_cnt_q + LEN_W'(1);
    end

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
  end

  // State, descriptor, counters, valid pipeline and output flops. Reset
  // also empties the valid pipeline so reads in flight never turn into
  // writes afterwards.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      vld_q     <= '0;
      re_a_q    <= 1'b0;
      addr_a_q  <= '0;
      we_b_q    <= 1'b0;
      addr_b_q  <= '0;
      wdata_b_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      vld_q     <= vld_d;
      re_a_q    <= re_a_d;
      addr_a_q  <= addr_a_d;
      we_b_q    <= we_b_d;
      addr_b_q  <= addr_b_d;
      wdata_b_q <= wdata_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.reA    = re_a_q;
  assign bus.addrA  = addr_a_q;
  assign bus.WEB    = we_b_q;
  assign bus.addrB  = addr_b_q;
  assign bus.wdataB = wdata_b_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_xfer_sequencer
//
// Drives two sequencer instances with identical controller stimulus: lane 0
// uses RD_LAT=1, lane 1 uses RD_LAT=3. Each lane has its own memory A model
// that returns addr+0x10 exactly RD_LAT cycles after a read. A transaction
// level model predicts every output of both lanes each cycle, and directed
// literal checks pin the key cycles of each scenario.
//
// Cycle numbering inside a scenario: cycle 0 is the cycle in which start is
// presented; cycle k begins at the k-th rising edge after that. An input
// presented during cycle k-1 is sampled at the edge that opens cycle k.
// ---------------------------------------------------------------------------
module tb_mem_xfer_sequencer;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int LEN_W = 5;
  localparam int NL    = 2;
  localparam int AMOD  = 1 << AW;

  logic clock = 1'b0;
  logic Reset;

  always #5 clock = ~clock;

  logic             start;
  logic             hold;
  logic [AW-1:0]    src_base;
  logic [AW-1:0]    dst_base;
  logic [LEN_W-1:0] length;

  logic [DW-1:0]    rdata   [NL];
  logic             re_a    [NL];
  logic [AW-1:0]    addr_a  [NL];
  logic             we_b    [NL];
  logic [AW-1:0]    addr_b  [NL];
  logic [DW-1:0]    wdata_b [NL];
  logic             busy    [NL];
  logic             done    [NL];

  int n_cmp  = 0;
  int n_fail = 0;
  int web_cnt [NL];

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Two sequencer instances differing only in read latency.
  generate
    for (genvar g = 0; g < NL; g++) begin : lane
      localparam int LAT = (g == 0) ? 1 : 3;

      mem_xfer_sequencer_if #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) bus ();

      assign bus.start    = start;
      assign bus.src_base = src_base;
      assign bus.dst_base = dst_base;
      assign bus.length   = length;
      assign bus.hold     = hold;
      assign bus.rdataA   = rdata[g];

      assign re_a[g]    = bus.reA;
      assign addr_a[g]  = bus.addrA;
      assign we_b[g]    = bus.WEB;
      assign addr_b[g]  = bus.addrB;
      assign wdata_b[g] = bus.wdataB;
      assign busy[g]    = bus.busy;
      assign done[g]    = bus.done;

      mem_xfer_sequencer #(
        .AW(AW), .DW(DW), .LEN_W(LEN_W), .RD_LAT(LAT)
      ) dut (
        .clock(clock),
        .Reset(Reset),
        .bus(bus)
      );
    end
  endgenerate

  // Memory A: the word at address a holds a+0x10. rdataA presented during
  // cycle c belongs to the address driven RD_LAT cycles earlier.
  logic [AW-1:0] hist [NL][5];

  initial begin
    for (int l = 0; l < NL; l++) begin
      rdata[l] = '0;
      for (int k = 0; k < 5; k++) hist[l][k] = '0;
    end
    forever begin
      @(negedge clock);
      for (int l = 0; l < NL; l++) begin
        rdata[l] = DW'(hist[l][lat_of(l) - 1]) + DW'(8'h10);
        for (int k = 4; k > 0; k--) hist[l][k] = hist[l][k-1];
        hist[l][0] = addr_a[l];
      end
    end
  end

  // Transaction-level reference: a running transfer issues one read per
  // non-held cycle, each read becomes the write of the same index
  // RD_LAT+1 cycles later, and done follows the cycle of the last write.
  bit model_on = 1'b0;
  int cyc = 0;
  bit p_reset, p_start, p_hold;
  int p_src, p_dst, p_len;
  bit m_run [NL];
  bit m_prev_done [NL];
  int m_src [NL], m_dst [NL], m_len [NL], m_iss [NL], m_wr [NL];
  int m_issue_cyc [NL][32];

  initial begin
    for (int l = 0; l < NL; l++) begin
      web_cnt[l] = 0;
      m_run[l] = 1'b0;
      m_prev_done[l] = 1'b0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      for (int l = 0; l < NL; l++) begin
        int  e_aa, e_ab, e_wd;
        bit  e_re, e_we, e_busy, e_done, chk_aa, chk_b, bad;
        e_re = 0; e_we = 0; e_busy = 0; e_done = 0;
        e_aa = 0; e_ab = 0; e_wd = 0; chk_aa = 0; chk_b = 0;
        if (we_b[l]) web_cnt[l]++;
        if (model_on) begin
          if (p_reset) begin
            m_run[l] = 1'b0;
            chk_aa = 1; chk_b = 1;
          end else begin
            if (m_run[l] && m_wr[l] == m_len[l]) begin
              e_done = 1;
              m_run[l] = 1'b0;
            end else if (m_run[l]) begin
              if (m_wr[l] < m_iss[l] &&
                  m_issue_cyc[l][m_wr[l]] + lat_of(l) + 1 == cyc) begin
                e_we = 1; chk_b = 1;
                e_ab = (m_dst[l] + m_wr[l]) % AMOD;
                e_wd = (((m_src[l] + m_wr[l]) % AMOD) + 16) % 256;
                m_wr[l]++;
              end
            end else if (p_start && !m_prev_done[l]) begin
              if (p_len == 0) begin
                e_done = 1;
              end else begin
                m_run[l] = 1'b1;
                m_src[l] = p_src; m_dst[l] = p_dst; m_len[l] = p_len;
                m_iss[l] = 0; m_wr[l] = 0;
              end
            end
            if (m_run[l] && m_iss[l] < m_len[l] && !p_hold) begin
              e_re = 1; chk_aa = 1;
              e_aa = (m_src[l] + m_iss[l]) % AMOD;
              m_issue_cyc[l][m_iss[l]] = cyc;
              m_iss[l]++;
            end
            e_busy = m_run[l];
          end
          m_prev_done[l] = e_done;

          bad = (re_a[l] !== e_re) || (we_b[l] !== e_we) ||
                (busy[l] !== e_busy) || (done[l] !== e_done) ||
                (chk_aa && int'(addr_a[l]) != e_aa) ||
                (chk_b && (int'(addr_b[l]) != e_ab || int'(wdata_b[l]) != e_wd));
          n_cmp++;
          if (bad) begin
            n_fail++;
            $display("[TB] FAIL model lane%0d cyc%0d: got reA=%0b addrA=%0d WEB=%0b addrB=%0d wdataB=%02h busy=%0b done=%0b, want reA=%0b addrA=%0d WEB=%0b addrB=%0d wdataB=%02h busy=%0b done=%0b",
                     l, cyc, re_a[l], addr_a[l], we_b[l], addr_b[l], wdata_b[l],
                     busy[l], done[l], e_re, e_aa, e_we, e_ab, e_wd, e_busy, e_done);
          end
        end
      end
      if (Reset) model_on = 1'b1;
      p_reset = Reset;
      p_start = start;
      p_hold  = hold;
      p_src   = int'(src_base);
      p_dst   = int'(dst_base);
      p_len   = int'(length);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit s, input int src, input int dst,
                               input int len, input bit h);
    start    = s;
    src_base = AW'(src);
    dst_base = AW'(dst);
    length   = LEN_W'(len);
    hold     = h;
  endtask

  task automatic checkOutput(input string name, input int l,
                             input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s lane%0d: got %0d, want %0d", name, l, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string name, input int l);
    checkOutput({name, " reA"},    l, int'(re_a[l]),    0);
    checkOutput({name, " addrA"},  l, int'(addr_a[l]),  0);
    checkOutput({name, " WEB"},    l, int'(we_b[l]),    0);
    checkOutput({name, " addrB"},  l, int'(addr_b[l]),  0);
    checkOutput({name, " wdataB"}, l, int'(wdata_b[l]), 0);
    checkOutput({name, " busy"},   l, int'(busy[l]),    0);
    checkOutput({name, " done"},   l, int'(done[l]),    0);
  endtask

  initial begin
    int base0, base1;
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    tick(3);
    Reset = 1'b0;
    tick(2);
    $display("[TB] basic copy src=0 dst=8 len=8");
    applyStimulus(1, 0, 8, 8, 0);
    tick(1);
    start = 1'b0;
    checkOutput("s2 reA c1", 0, int'(re_a[0]), 1);
    checkOutput("s2 addrA c1", 0, int'(addr_a[0]), 0);
    checkOutput("s2 busy c1", 0, int'(busy[0]), 1);
    tick(2);
    checkOutput("s2 WEB c3", 0, int'(we_b[0]), 1);
    checkOutput("s2 addrB c3", 0, int'(addr_b[0]), 8);
    checkOutput("s2 wdataB c3", 0, int'(wdata_b[0]), 'h10);
    tick(5);
    checkOutput("s2 addrA c8", 0, int'(addr_a[0]), 7);
    tick(1);
    checkOutput("s2 reA c9", 0, int'(re_a[0]), 0);
    tick(1);
    checkOutput("s2 addrB c10", 0, int'(addr_b[0]), 15);
    checkOutput("s2 wdataB c10", 0, int'(wdata_b[0]), 'h17);
    checkOutput("s2 busy c10", 0, int'(busy[0]), 1);
    tick(1);
    checkOutput("s2 done c11", 0, int'(done[0]), 1);
    checkOutput("s2 busy c11", 0, int'(busy[0]), 0);
    tick(1);
    checkOutput("s2 done c12", 0, int'(done[0]), 0);
    tick(4);

    $display("[TB] reset while idle");
    Reset = 1'b1;
    tick(2);
    for (int l = 0; l < NL; l++) checkAllZero("s1 idle reset", l);
    Reset = 1'b0;
    tick(2);

    $display("[TB] hold during issue");
    applyStimulus(1, 0, 8, 8, 0);
    tick(1);
    start = 1'b0;
    tick(2);
    hold = 1'b1;
    tick(1);
    checkOutput("s3 reA c4", 0, int'(re_a[0]), 0);
    tick(2);
    checkOutput("s3 reA c6", 0, int'(re_a[0]), 0);
    checkOutput("s3 WEB c6", 0, int'(we_b[0]), 0);
    hold = 1'b0;
    tick(1);
    checkOutput("s3 reA c7", 0, int'(re_a[0]), 1);
    checkOutput("s3 addrA c7", 0, int'(addr_a[0]), 3);
    tick(4);
    checkOutput("s3 addrA c11", 0, int'(addr_a[0]), 7);
    tick(2);
    checkOutput("s3 addrB c13", 0, int'(addr_b[0]), 15);
    checkOutput("s3 wdataB c13", 0, int'(wdata_b[0]), 'h17);
    tick(1);
    checkOutput("s3 done c14", 0, int'(done[0]), 1);
    tick(4);

    $display("[TB] zero length and start while busy");
    applyStimulus(1, 2, 3, 0, 0);
    tick(1);
    start = 1'b0;
    for (int l = 0; l < NL; l++) begin
      checkOutput("s4 done zero-len", l, int'(done[l]), 1);
      checkOutput("s4 reA zero-len", l, int'(re_a[l]), 0);
      checkOutput("s4 busy zero-len", l, int'(busy[l]), 0);
    end
    tick(1);
    checkOutput("s4 done after pulse", 0, int'(done[0]), 0);
    tick(2);
    base0 = web_cnt[0];
    base1 = web_cnt[1];
    applyStimulus(1, 4, 20, 4, 0);
    tick(1);
    start = 1'b0;
    tick(1);
    applyStimulus(1, 9, 9, 7, 0);
    tick(1);
    start = 1'b0;
    tick(10);
    checkOutput("s4 write count", 0, web_cnt[0] - base0, 4);
    checkOutput("s4 write count", 1, web_cnt[1] - base1, 4);

    $display("[TB] address wrap, lane 1 latency 3");
    applyStimulus(1, 30, 31, 4, 0);
    tick(1);
    start = 1'b0;
    checkOutput("s5 addrA c1", 1, int'(addr_a[1]), 30);
    tick(1);
    checkOutput("s5 addrA c2", 1, int'(addr_a[1]), 31);
    tick(1);
    checkOutput("s5 addrA c3", 1, int'(addr_a[1]), 0);
    checkOutput("s5 addrB c3", 0, int'(addr_b[0]), 31);
    checkOutput("s5 wdataB c3", 0, int'(wdata_b[0]), 'h2E);
    tick(1);
    checkOutput("s5 addrA c4", 1, int'(addr_a[1]), 1);
    checkOutput("s5 WEB c4", 1, int'(we_b[1]), 0);
    tick(1);
    checkOutput("s5 WEB c5", 1, int'(we_b[1]), 1);
    checkOutput("s5 addrB c5", 1, int'(addr_b[1]), 31);
    checkOutput("s5 wdataB c5", 1, int'(wdata_b[1]), 'h2E);
    tick(2);
    checkOutput("s5 addrB c7", 1, int'(addr_b[1]), 1);
    checkOutput("s5 wdataB c7", 1, int'(wdata_b[1]), 'h10);
    tick(1);
    checkOutput("s5 addrB c8", 1, int'(addr_b[1]), 2);
    tick(1);
    checkOutput("s5 done c9", 1, int'(done[1]), 1);
    tick(3);

    $display("[TB] reset mid-transfer then restart");
    applyStimulus(1, 0, 8, 8, 0);
    tick(1);
    start = 1'b0;
    tick(3);
    Reset = 1'b1;
    tick(1);
    for (int l = 0; l < NL; l++) checkAllZero("s6 mid reset", l);
    Reset = 1'b0;
    tick(1);
    checkOutput("s6 WEB c6", 0, int'(we_b[0]), 0);
    checkOutput("s6 busy c6", 0, int'(busy[0]), 0);
    applyStimulus(1, 3, 5, 5, 0);
    tick(1);
    start = 1'b0;
    checkOutput("s6 reA c7", 0, int'(re_a[0]), 1);
    checkOutput("s6 addrA c7", 0, int'(addr_a[0]), 3);
    tick(2);
    checkOutput("s6 addrB c9", 0, int'(addr_b[0]), 5);
    checkOutput("s6 wdataB c9", 0, int'(wdata_b[0]), 'h13);
    tick(4);
    checkOutput("s6 addrB c13", 0, int'(addr_b[0]), 9);
    checkOutput("s6 wdataB c13", 0, int'(wdata_b[0]), 'h17);
    tick(1);
    checkOutput("s6 done c14", 0, int'(done[0]), 1);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_xfer_sequencer.md
Name: mem_xfer_sequencer

Overview:
- Programmable sequencer for memory-to-memory copies from memory A to memory B.
- On a start pulse it latches source base, destination base and length.
- It issues sequential reads to memory A, tracks A's fixed read latency with a valid pipeline, and issues matching registered writes to memory B with the returned data.
- It replaces hard-coded transfer sequencing with a start/busy/done handshake driven by the system controller.

Parameters:
AW, 5, address width of memories A and B
DW, 8, data word width
LEN_W, 5, width of the length field (max transfer 2^LEN_W-1 words)
RD_LAT, 1, memory A read latency in cycles (legal 1..4)

Ports:
clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a transfer
src_base  in  AW  first memory A address
dst_base  in  AW  first memory B address
length  in  LEN_W  number of words to copy
hold  in  1  when high, suspends issue of new reads
rdataA  in  DW  memory A read data, valid RD_LAT cycles after the read
reA  out  1  memory A read enable
addrA  out  AW  memory A read address
WEB  out  1  memory B write enable
addrB  out  AW  memory B write address
wdataB  out  DW  memory B write data
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clock); Reset is synchronous, active-high.
- Outputs: all outputs are registered. Reset forces reA, addrA, WEB, addrB, wdataB, busy and done to 0. Reset also clears counters and the valid pipeline, and sets the state to IDLE.
- Reset mid-transfer: any in-flight reads are discarded. No WEB is asserted after the Reset edge.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with length!=0: latch src, dst and len; clear rd_cnt and wr_cnt; next state is ISSUE. busy=1 from the first ISSUE cycle.
  - start=1 with length=0: next state is DONE. No reads or writes occur.
  - start while not in IDLE is ignored.
- ISSUE, each cycle:
  - hold=0: reA=1, addrA=(src+rd_cnt) mod 2^AW, rd_cnt++.
  - hold=1: reA=0 and rd_cnt is unchanged.
  - After the read with rd_cnt=len-1 is issued, the next state is DRAIN.
- Valid pipeline:
  - A read asserted in cycle t returns rdataA sampled at the end of cycle t+RD_LAT.
  - In cycle t+RD_LAT+1: WEB=1, addrB=(dst+wr_cnt) mod 2^AW, wdataB=that rdataA, and wr_cnt++.
  - WEB is 0 in all other cycles.
  - reA-to-WEB latency is exactly RD_LAT+1 cycles. Write order equals read order, and gaps are preserved.
- hold: affects only new issues. In-flight writes complete regardless, and hold has no effect in DRAIN.
- DRAIN: stay until wr_cnt==len, i.e. the cycle after the last WEB, then move to DONE.
- DONE: done=1 for exactly one cycle, busy=0, next state is IDLE. A start is accepted in the cycle following done.
- Address arithmetic: addresses wrap modulo 2^AW.
  - Counters are LEN_W wide.
  - len words are written exactly once each.
- Overlap: A and B are separate memories, so no hazard checking is done.

Test Plan:
1. Reset: assert Reset 2 cycles mid-idle -> reA, WEB, busy, done, addrA, addrB, wdataB all 0.
2. Basic copy (RD_LAT=1): start with src=0, dst=8, len=8, rdataA=addr+0x10 -> reA cycles 1-8 with addrA 0..7; WEB cycles 3-10 with addrB 8..15 and wdataB 0x10..0x17; done cycle 11 only; busy cycles 1-10.
3. Hold: same as scenario 2 but hold=1 in cycles 4-6 -> reA low cycles 4-6; addrA continues 3..7 in cycles 7-11; WEB data/address sequence unchanged; done cycle 14.
4. Zero length and busy start: start with len=0 -> done pulse next cycle, no reA/WEB. Then start len=4 followed by a second start 2 cycles later -> second start ignored, exactly 4 writes.
5. Wrap and latency: RD_LAT=3, src=30, dst=31, len=4 -> addrA 30,31,0,1; addrB 31,0,1,2; each WEB exactly 4 cycles after its reA.
6. Reset mid-operation: Reset in ISSUE cycle 4 of an 8-word copy -> from the next cycle all outputs 0, no further WEB; a new start 2 cycles later runs a complete, correct transfer.
